seq_div_unit: RTL and testbench

SEQ_DIV_UNIT -- requirements
Module: seq_div_unit

---
 rtl/seq_div_pkg.sv | 15 +
 rtl/seq_div_step.sv | 21 ++
 rtl/seq_div_unit.sv | 137 +++++++++++++
 tb/tb_seq_div_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;
  localparam int DIV_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Wide enough to hold the step count WIDTH itself.
  function automatic int div_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, compare and
// conditionally subtract the divisor, emit one quotient bit.
module seq_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_ge    = w_shift >= {2'b00, i_div};
  assign w_sub   = w_shift[WIDTH:0] - {1'b0, i_div};
  assign o_rem   = w_ge ? w_sub : w_shift[WIDTH:0];
  assign o_quo   = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/seq_div_unit.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready I/O.
// Define SEQ_DIV_SIGNED_EN to add op_signed and two's-complement division.
module seq_div_unit import seq_div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             op_signed,
`endif
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);
  localparam int CNT_W = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  div_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_b, r_quo, r_q_out, r_r_out;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dbz;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt, w_a_ld, w_b_ld;
  logic             w_steps_done, w_calc_end;

  assign w_steps_done = (r_cnt == LAST);

`ifdef SEQ_DIV_SIGNED_EN
  logic r_sgn, r_fix, r_neg_q, r_neg_r;
  // Divide magnitudes; signs are re-applied in the fixup cycle.
  assign w_a_ld     = (op_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_b_ld     = (op_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_calc_end = w_steps_done && (!r_sgn || r_fix);
`else
  assign w_a_ld     = dividend;
  assign w_b_ld     = divisor;
  assign w_calc_end = w_steps_done;
`endif

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_b),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start_valid) w_state_nxt = (divisor == '0) ? DONE : CALC;
      CALC:    if (w_calc_end)  w_state_nxt = DONE;
      DONE:    if (res_ready)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      r_sgn   <= 1'b0;
      r_fix   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: if (start_valid) begin
          r_b   <= w_b_ld;
          r_quo <= w_a_ld;
          r_rem <= '0;
          r_cnt <= '0;
`ifdef SEQ_DIV_SIGNED_EN
          r_sgn   <= op_signed;
          r_fix   <= 1'b0;
          r_neg_q <= op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_r <= op_signed & dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            r_q_out <= '0;
            r_r_out <= '0;
            r_dbz   <= 1'b1;
          end
        end
        CALC: if (!w_steps_done) begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
          if (r_sgn && !r_fix) begin
            r_fix <= 1'b1;
            r_quo <= r_neg_q ? -r_quo : r_quo;
            r_rem <= {1'b0, r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]};
          end else begin
            r_q_out <= r_quo;
            r_r_out <= r_rem[WIDTH-1:0];
            r_dbz   <= 1'b0;
          end
`else
          r_q_out <= r_quo;
          r_r_out <= r_rem[WIDTH-1:0];
          r_dbz   <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign res_valid   = (r_state == DONE);
  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_div_unit.sv
// Directed bench for seq_div_unit (WIDTH=8); signed cases run when
// SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         start_ready, res_valid, div_by_zero, busy;
  logic [W-1:0] quotient, remainder;
`ifdef SEQ_DIV_SIGNED_EN
  logic         op_signed = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SEQ_DIV_SIGNED_EN
    .op_signed   (op_signed),
`endif
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair through a single accept edge.
  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  // Cycles from the accept edge until res_valid; -1 if it never comes.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (res_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL rst_start_ready got %b want 1", start_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    total++; if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL rst_result got q=%0d r=%0d z=%b want 0 0 0", quotient, remainder, div_by_zero);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_unsigned();
    int n;
    res_ready = 1'b1;
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL u_ready got %b want 1", start_ready); end
    offer(8'd200, 8'd7);
    wait_valid(n);
    total++; if (n !== 9) begin bad++; $display("FAIL u_latency got %0d want 9", n); end
    total++; if (quotient !== 8'd28) begin bad++; $display("FAIL u_quot got %0d want 28", quotient); end
    total++; if (remainder !== 8'd4) begin bad++; $display("FAIL u_rem got %0d want 4", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL u_dbz got %b want 0", div_by_zero); end
    step();
    total++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++; $display("FAIL u_idle got ready=%b valid=%b want 1 0", start_ready, res_valid);
    end
  endtask

  task automatic test_div_zero();
    res_ready = 1'b1;
    offer(8'd55, 8'd0);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL z_valid got %b want 1", res_valid); end
    total++; if (quotient !== 8'd0 || remainder !== 8'd0) begin
      bad++; $display("FAIL z_result got q=%0d r=%0d want 0 0", quotient, remainder);
    end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL z_flag got %b want 1", div_by_zero); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL z_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_hold();
    int n;
    int sr_bad;
    res_ready = 1'b0;
    offer(8'd255, 8'd1);
    n = -1;
    sr_bad = 0;
    for (int i = 1; i <= 30; i++) begin
      if (start_ready !== 1'b0) sr_bad++;
      step();
      if (res_valid) begin
        n = i;
        break;
      end
    end
    total++; if (n !== 9) begin bad++; $display("FAIL h_latency got %0d want 9", n); end
    total++; if (sr_bad !== 0) begin bad++; $display("FAIL h_ready_calc got %0d cycles high want 0", sr_bad); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (res_valid !== 1'b1 || quotient !== 8'd255 || remainder !== 8'd0 || start_ready !== 1'b0) begin
        bad++;
        $display("FAIL h_stable[%0d] got v=%b q=%0d r=%0d rdy=%b want 1 255 0 0",
                 k, res_valid, quotient, remainder, start_ready);
      end
      step();
    end
    res_ready = 1'b1;
    step();
    total++; if (start_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL h_idle got rdy=%b busy=%b want 1 0", start_ready, busy);
    end
    total++; if (quotient !== 8'd255 || remainder !== 8'd0) begin
      bad++; $display("FAIL h_kept got q=%0d r=%0d want 255 0", quotient, remainder);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int seen;
    res_ready = 1'b1;
    offer(8'd100, 8'd3);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    total++; if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL ra_ctrl got rdy=%b busy=%b v=%b want 1 0 0", start_ready, busy, res_valid);
    end
    total++; if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL ra_result got q=%0d r=%0d z=%b want 0 0 0", quotient, remainder, div_by_zero);
    end
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      step();
      if (res_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL ra_no_valid got %0d want 0", seen); end
    offer(8'd9, 8'd2);
    wait_valid(n);
    total++; if (n !== 9 || quotient !== 8'd4 || remainder !== 8'd1) begin
      bad++; $display("FAIL ra_next got n=%0d q=%0d r=%0d want 9 4 1", n, quotient, remainder);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int acc;
    res_ready   = 1'b0;
    dividend    = 8'd50;
    divisor     = 8'd5;
    start_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (start_valid && start_ready) acc++;
      step();
      if (i == 0) begin
        dividend = 8'd99;
        divisor  = 8'd2;
      end
    end
    total++; if (acc !== 1) begin bad++; $display("FAIL bb_accepts got %0d want 1", acc); end
    total++; if (res_valid !== 1'b1 || quotient !== 8'd10 || remainder !== 8'd0) begin
      bad++; $display("FAIL bb_result got v=%b q=%0d r=%0d want 1 10 0", res_valid, quotient, remainder);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    step();
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL bb_idle got %b want 1", start_ready); end
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed();
    int n;
    op_signed = 1'b1;
    res_ready = 1'b1;
    offer(8'hF9, 8'd2);
    wait_valid(n);
    total++; if (n !== 10) begin bad++; $display("FAIL s_latency got %0d want 10", n); end
    total++; if (quotient !== 8'hFD || remainder !== 8'hFF) begin
      bad++; $display("FAIL s_m7_2 got q=%h r=%h want fd ff", quotient, remainder);
    end
    step();
    offer(8'h80, 8'hFF);
    wait_valid(n);
    total++; if (n !== 10 || quotient !== 8'h80 || remainder !== 8'h00) begin
      bad++; $display("FAIL s_min_m1 got n=%0d q=%h r=%h want 10 80 00", n, quotient, remainder);
    end
    step();
    op_signed = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_hold();
    test_reset_abort();
    test_back_to_back();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
